// File: rtl/multdiv_sequencer.sv
// Issue sequencer for the shared multi-cycle multiply/divide unit: latches operands,
// pulses the unit's start controls, arbitrates the regfile write port and raises decode stalls.
module multdiv_sequencer #(
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic        issue_ready,

    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,

    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,

    input  logic        wb_pipe_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,

    output logic        stall_out,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [4:0] EXC_RD = 5'd30;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        WB_WAIT
    } state_t;

    state_t             state;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [31:0]        res_data;
    logic [4:0]         tgt;
    logic               op_is_div;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [STV_W-1:0]   starve_cnt;
    logic               err_q;

    logic               in_flight;
    logic               dep_stall;
    logic               starve_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            res_data   <= '0;
            tgt        <= '0;
            op_is_div  <= 1'b0;
            cyc_cnt    <= '0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        op_a      <= issue_a;
                        op_b      <= issue_b;
                        tgt       <= issue_rd;
                        op_is_div <= issue_is_div;
                        state     <= START;
                    end
                end
                START: begin
                    cyc_cnt <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    if (md_ready) begin
                        starve_cnt <= '0;
                        if (md_exception) begin
                            // Exceptions are reported through r30 with a cause code.
                            tgt      <= EXC_RD;
                            res_data <= op_is_div ? 32'd5 : 32'd4;
                            state    <= WB_WAIT;
                        end else begin
                            res_data <= md_result;
                            state    <= (tgt == '0) ? IDLE : WB_WAIT;
                        end
                    end else if (cyc_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                WB_WAIT: begin
                    if (!wb_pipe_valid) begin
                        state <= IDLE;
                    end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + STV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_flight    = (state == START) || (state == BUSY);
    assign busy         = (state != IDLE);
    assign issue_ready  = (state == IDLE);
    assign err_timeout  = err_q;

    assign md_ctrl_mult = (state == START) && !op_is_div;
    assign md_ctrl_div  = (state == START) && op_is_div;
    assign md_a         = in_flight ? op_a : '0;
    assign md_b         = in_flight ? op_b : '0;

    assign wb_valid     = (state == WB_WAIT) && !wb_pipe_valid;
    assign wb_rd        = wb_valid ? tgt : '0;
    assign wb_data      = wb_valid ? res_data : '0;

    // Until the result arrives an exception could still redirect the write to r30.
    assign dep_stall    = busy &&
                          (((tgt != '0) && ((dec_rs1 == tgt) || (dec_rs2 == tgt))) ||
                           (in_flight && ((dec_rs1 == EXC_RD) || (dec_rs2 == EXC_RD))));
    assign starve_stall = (state == WB_WAIT) && (starve_cnt == STV_W'(STARVE_LIMIT));
    assign stall_out    = dep_stall || starve_stall;

endmodule
